// File: rtl/pio_fifo_capture_pkg.sv
// Shared constants and types for the PIO-driven sample-capture FIFO.
// PIO bit positions and the capture FSM state encoding live here.
package pio_fifo_capture_pkg;

  localparam int CTRL_ARM_BIT   = 0;
  localparam int CTRL_CLR_BIT   = 1;
  localparam int CTRL_RDREQ_BIT = 2;
  localparam int STAT_ACK_BIT   = 0;
  localparam int STAT_EMPTY_BIT = 1;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_e;

endpackage

// File: rtl/pio_fifo_capture_ram.sv
// Simple dual-port sample store: registered write, combinational read,
// shaped so synthesis maps it onto distributed or block RAM.
module pio_fifo_capture_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: storage has no reset so it maps onto RAM primitives; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pio_fifo_capture_ctrl.sv
// Capture FIFO controlled by a 5-bit PIO: arm/clear/rd_req toggle in, rd_ack/empty out.
// Define PIO_CTRL_SYNC_EN to pass pio_ctrl through a 2-flop synchronizer first.
module pio_fifo_capture_ctrl
  import pio_fifo_capture_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        pio_ctrl,
  output logic [1:0]        pio_status,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [AW:0]       fill_level,
  output logic              overflow,
  output logic              underrun,
  output logic              capturing
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [2:0] ctrl;

`ifdef PIO_CTRL_SYNC_EN
  logic [2:0] sync_1, sync_2;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
    end else begin
      sync_1 <= pio_ctrl;
      sync_2 <= sync_1;
    end
  end

  assign ctrl = sync_2;
`else
  assign ctrl = pio_ctrl;
`endif

  logic arm, clr, rd_req;
  assign arm    = ctrl[CTRL_ARM_BIT];
  assign clr    = ctrl[CTRL_CLR_BIT];
  assign rd_req = ctrl[CTRL_RDREQ_BIT];

  state_e state, state_nxt;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (arm)  state_nxt = CAPTURE;
        CAPTURE: if (!arm) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  logic [AW-1:0]     wptr, rptr;
  logic              rd_req_q, empty_q;
  logic [DATA_W-1:0] ram_rdata;
  logic              full, in_cap, req_seen, push, pop, drop;
  logic [AW:0]       fill_nxt;

  assign in_cap   = (state == CAPTURE);
  assign full     = (fill_level == FULL_LVL);
  assign req_seen = (rd_req != rd_req_q);
  assign push     = in_cap && sample_valid && !full && !clr;
  assign pop      = req_seen && (fill_level != '0) && !clr;
  assign drop     = in_cap && sample_valid && full;

  always_comb begin
    fill_nxt = fill_level;
    if (push && !pop)      fill_nxt = fill_level + (AW+1)'(1);
    else if (pop && !push) fill_nxt = fill_level - (AW+1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fill_level <= '0;
      empty_q    <= 1'b1;
      rd_data    <= '0;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
      rd_req_q   <= 1'b0;
    end else if (clr) begin
      wptr       <= '0;
      rptr       <= '0;
      fill_level <= '0;
      empty_q    <= 1'b1;
      overflow   <= 1'b0;
      underrun   <= 1'b0;
      rd_req_q   <= rd_req;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop) begin
        rptr    <= rptr + AW'(1);
        rd_data <= ram_rdata;
      end
      fill_level <= fill_nxt;
      empty_q    <= (fill_nxt == '0);
      if (drop) overflow <= 1'b1;
      if (req_seen && fill_level == '0) underrun <= 1'b1;
      // The request history doubles as the ack echo, so ack lags rd_req by one clk.
      rd_req_q <= rd_req;
    end
  end

  pio_fifo_capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wptr),
    .wdata (sample_data),
    .raddr (rptr),
    .rdata (ram_rdata)
  );

  assign pio_status[STAT_ACK_BIT]   = rd_req_q;
  assign pio_status[STAT_EMPTY_BIT] = empty_q;
  assign capturing                  = in_cap;

endmodule

// File: tb/tb_pio_fifo_capture_ctrl.sv
// Self-checking bench for pio_fifo_capture_ctrl against a queue-based reference model.
// Honours PIO_CTRL_SYNC_EN by modelling the extra two clocks of control latency.
module tb_pio_fifo_capture_ctrl;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
`ifdef PIO_CTRL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              reset_n;
  logic [2:0]        pio_ctrl;
  logic [1:0]        pio_status;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic [DATA_W-1:0] rd_data;
  logic [4:0]        fill_level;
  logic              overflow, underrun, capturing;

  pio_fifo_capture_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pio_ctrl     (pio_ctrl),
    .pio_status   (pio_status),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .rd_data      (rd_data),
    .fill_level   (fill_level),
    .overflow     (overflow),
    .underrun     (underrun),
    .capturing    (capturing)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic arm_r = 1'b0, clr_r = 1'b0, req_r = 1'b0;

  // Reference model: a plain queue plus the flag bits the firmware sees.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_rd  = '0;
  logic              m_ovf = 1'b0, m_und = 1'b0, m_ack = 1'b0, m_cap = 1'b0;
  logic [2:0]        m_s1 = '0, m_s2 = '0;

  task automatic model_step();
    logic [2:0] eff;
    logic       full, do_push;
    if (!reset_n) begin
      q.delete();
      m_rd = '0; m_ovf = 1'b0; m_und = 1'b0; m_ack = 1'b0; m_cap = 1'b0;
      m_s1 = '0; m_s2 = '0;
      return;
    end
    if (LAT == 3) begin
      eff = m_s2; m_s2 = m_s1; m_s1 = pio_ctrl;
    end else begin
      eff = pio_ctrl;
    end
    if (eff[1]) begin
      q.delete();
      m_ovf = 1'b0; m_und = 1'b0; m_ack = eff[2]; m_cap = 1'b0;
      return;
    end
    full    = (q.size() == DEPTH);
    do_push = m_cap && sample_valid && !full;
    if (m_cap && sample_valid && full) m_ovf = 1'b1;
    if (eff[2] != m_ack) begin
      if (q.size() != 0) m_rd = q.pop_front();
      else               m_und = 1'b1;
      m_ack = eff[2];
    end
    if (do_push) q.push_back(sample_data);
    m_cap = eff[0];
  endtask

  function automatic logic [25:0] exp_vec();
    return {5'(q.size()), q.size() == 0, m_ack, m_ovf, m_und, m_cap, m_rd};
  endfunction

  function automatic logic [25:0] dut_vec();
    return {fill_level, pio_status[1], pio_status[0], overflow, underrun, capturing, rd_data};
  endfunction

  task automatic tick(input logic sv, input logic [DATA_W-1:0] sd);
    pio_ctrl     = {req_r, clr_r, arm_r};
    sample_valid = sv;
    sample_data  = sd;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; arm_r = 1'b1;
    tick(1'b1, 16'hABCD);
    tick(1'b1, 16'h1234);
    checks++;
    if ({fill_level, pio_status[1], rd_data, pio_status[0], capturing} !== {5'd0, 1'b1, 16'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got fill=%0d empty=%b rd=%h ack=%b cap=%b, want 0 1 0000 0 0",
               fill_level, pio_status[1], rd_data, pio_status[0], capturing);
    end
    arm_r = 1'b0;
    tick(1'b0, '0);
    reset_n = 1'b1;
    tick(1'b0, '0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_model: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_arm_latency();
    int n = 0;
    arm_r = 1'b1;
    do begin tick(1'b0, '0); n++; end while (!capturing && n < 8);
    checks++;
    if (n != LAT) begin
      errors++; $display("FAIL arm_latency: got %0d clk want %0d", n, LAT);
    end
  endtask

  task automatic pop_one(input string name, input logic [DATA_W-1:0] want);
    int n = 0;
    req_r = ~req_r;
    do begin tick(1'b0, '0); n++; end while (pio_status[0] !== req_r && n < 8);
    checks++;
    if (n != LAT || rd_data !== want) begin
      errors++;
      $display("FAIL %s: got latency=%0d data=%h want latency=%0d data=%h", name, n, rd_data, LAT, want);
    end
  endtask

  task automatic test_fifo_order();
    for (int i = 1; i <= 5; i++) tick(1'b1, DATA_W'(i));
    checks++;
    if (fill_level !== 5'd5) begin
      errors++; $display("FAIL order_fill: got %0d want 5", fill_level);
    end
    for (int i = 1; i <= 5; i++) pop_one("order_pop", DATA_W'(i));
    checks++;
    if (pio_status[1] !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL order_empty: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_overflow_wrap();
    for (int i = 1; i <= 20; i++) tick(1'b1, DATA_W'(i));
    checks++;
    if (fill_level !== 5'd16 || overflow !== 1'b1) begin
      errors++; $display("FAIL overflow: got fill=%0d ovf=%b want 16 1", fill_level, overflow);
    end
    for (int i = 1; i <= 16; i++) pop_one("drain_1", DATA_W'(i));
    for (int i = 0; i < 16; i++) tick(1'b1, DATA_W'(16'h0100 + i));
    checks++;
    if (fill_level !== 5'd16 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL refill: got %h want %h", dut_vec(), exp_vec());
    end
    for (int i = 0; i < 16; i++) pop_one("drain_wrap", DATA_W'(16'h0100 + i));
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) tick(1'b1, DATA_W'(16'h0200 + i));
    req_r = ~req_r;
    repeat (LAT - 1) tick(1'b0, '0);
    tick(1'b1, 16'h0203);
    checks++;
    if (fill_level !== 5'd3 || rd_data !== 16'h0200 || pio_status[0] !== req_r) begin
      errors++;
      $display("FAIL push_pop: got fill=%0d rd=%h ack=%b want 3 0200 %b", fill_level, rd_data, pio_status[0], req_r);
    end
  endtask

  task automatic test_underrun_clear();
    logic [DATA_W-1:0] held;
    for (int i = 1; i <= 3; i++) pop_one("pre_drain", DATA_W'(16'h0200 + i));
    held = rd_data;
    pop_one("underrun_ack", held);
    checks++;
    if (underrun !== 1'b1 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL underrun: got %h want %h", dut_vec(), exp_vec());
    end
    clr_r = 1'b1;
    tick(1'b0, '0);
    clr_r = 1'b0;
    repeat (LAT) tick(1'b0, '0);
    checks++;
    if ({overflow, underrun, fill_level, pio_status[0], rd_data} !== {1'b0, 1'b0, 5'd0, req_r, held}) begin
      errors++;
      $display("FAIL clear: got ovf=%b und=%b fill=%0d ack=%b rd=%h want 0 0 0 %b %h",
               overflow, underrun, fill_level, pio_status[0], rd_data, req_r, held);
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL clear_model: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      clr_r   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 29) == 0) arm_r = ~arm_r;
      if ($urandom_range(0, 3) == 0)  req_r = ~req_r;
      if (!reset_n) req_r = 1'b0;
      tick($urandom_range(0, 1) == 1, DATA_W'($urandom));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random[%0d]: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    reset_n = 1'b1; clr_r = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; pio_ctrl = '0; sample_valid = 1'b0; sample_data = '0;
    test_reset();
    test_arm_latency();
    test_fifo_order();
    test_overflow_wrap();
    test_simultaneous();
    test_underrun_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
